// File: rtl/r_skid_reg.sv
// r_skid_reg - two-entry valid/ready skid buffer.
//
// Cuts every combinational path between the upstream and downstream
// handshakes (s_ready, m_valid and m_data are all flop outputs) while still
// sustaining one transfer per clock. All storage is built from r_reg.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset
//   s_data   in   W   upstream data, taken when s_valid & s_ready
//   s_valid  in   1   upstream offers s_data
//   s_ready  out  1   block can accept a word (registered)
//   m_data   out  W   downstream data, straight from the main register
//   m_valid  out  1   m_data holds a word (registered)
//   m_ready  in   1   downstream takes m_data this cycle

`ifndef REUSABLES_REG_CLK_RISING
`define REUSABLES_REG_CLK_RISING 1
`endif
`ifndef REUSABLES_REG_RESET_ACTIVE_HIGH
`define REUSABLES_REG_RESET_ACTIVE_HIGH 1
`endif
`ifndef REUSABLES_REG_RESET_SYNC
`define REUSABLES_REG_RESET_SYNC 1
`endif

// r_reg - enabled register with synchronous active-high reset.
//   clk in 1, reset in 1, i_en in 1 (load enable), i_d in W, o_q out W.
module r_reg #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk) begin
        if (reset)
            o_q <= RST_VAL;
        else if (i_en)
            o_q <= i_d;
    end
endmodule

module r_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);
    localparam bit CFG_OK = (`REUSABLES_REG_CLK_RISING != 0) &&
                            (`REUSABLES_REG_RESET_ACTIVE_HIGH != 0) &&
                            (`REUSABLES_REG_RESET_SYNC != 0);

    if (!CFG_OK) begin : g_cfg_err
        $error("R_STATIC_ERROR: r_skid_reg needs rising clock, active-high synchronous reset");
    end
    if (W < 1) begin : g_w_err
        $error("R_STATIC_ERROR: r_skid_reg needs W >= 1");
    end

    // State is the pair of registered handshake outputs, {m_valid, s_ready}.
    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_EMPTY = 2'b01,
        ST_FULL  = 2'b10,
        ST_BUSY  = 2'b11
    } state_t;

    logic         r_m_valid, r_s_ready;
    logic [W-1:0] r_m_q, r_k_q;
    logic         w_m_valid_nxt, w_s_ready_nxt;
    logic         w_m_en, w_m_sel_k, w_k_en;
    logic [W-1:0] w_m_d;
    logic         w_in, w_out;
    state_t       w_state;

    assign w_in    = s_valid & r_s_ready;
    assign w_out   = r_m_valid & m_ready;
    assign w_state = state_t'({r_m_valid, r_s_ready});

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_ready_nxt = r_s_ready;
        w_m_en        = 1'b0;
        w_m_sel_k     = 1'b0;
        w_k_en        = 1'b0;
        case (w_state)
            ST_RST: begin
                // Only reachable through reset; leave for EMPTY once released.
                w_m_valid_nxt = 1'b0;
                w_s_ready_nxt = 1'b1;
            end
            ST_EMPTY: begin
                if (w_in) begin
                    w_m_en        = 1'b1;
                    w_m_valid_nxt = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_in && w_out) begin
                    w_m_en = 1'b1;
                end else if (w_in) begin
                    // Downstream stalled: park the new word in the skid entry
                    // and stop upstream from the next cycle on.
                    w_k_en        = 1'b1;
                    w_s_ready_nxt = 1'b0;
                end else if (w_out) begin
                    w_m_valid_nxt = 1'b0;
                end
            end
            ST_FULL: begin
                if (w_out) begin
                    w_m_en        = 1'b1;
                    w_m_sel_k     = 1'b1;
                    w_s_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_m_valid_nxt = 1'b0;
                w_s_ready_nxt = 1'b0;
            end
        endcase
    end

    assign w_m_d = w_m_sel_k ? r_k_q : s_data;

    r_reg #(.W(W)) u_main (
        .clk(clk), .reset(reset), .i_en(w_m_en), .i_d(w_m_d), .o_q(r_m_q)
    );
    r_reg #(.W(W)) u_skid (
        .clk(clk), .reset(reset), .i_en(w_k_en), .i_d(s_data), .o_q(r_k_q)
    );
    r_reg #(.W(1)) u_mvalid (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(w_m_valid_nxt), .o_q(r_m_valid)
    );
    r_reg #(.W(1)) u_sready (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(w_s_ready_nxt), .o_q(r_s_ready)
    );

    assign m_data  = r_m_q;
    assign m_valid = r_m_valid;
    assign s_ready = r_s_ready;
endmodule
